// File: rtl/blk_mem_responder.sv
// blk_mem_responder: 256-bit line store serving I-side reads and
// D-side reads/writes through one arbitrated port, fixed latency.
// Ports: CLK, RESET (async, high); i_addr, iBlkRead ->
//   i_block_read, i_block_read_valid; d_addr, dBlkRead, dBlkWrite,
//   d_block_write -> d_block_read, d_block_read_valid,
//   d_block_write_valid; busy.
// Option: BLKMEM_DPRIO_EN gives D fixed priority on a tie
//   (default: round-robin).
module blk_mem_responder #(
  parameter int LATENCY   = 4,
  parameter int LINE_BITS = 10
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  i_addr,
  input  logic         iBlkRead,
  output logic [255:0] i_block_read,
  output logic         i_block_read_valid,
  input  logic [31:0]  d_addr,
  input  logic         dBlkRead,
  input  logic         dBlkWrite,
  input  logic [255:0] d_block_write,
  output logic [255:0] d_block_read,
  output logic         d_block_read_valid,
  output logic         d_block_write_valid,
  output logic         busy
);

  localparam int DEPTH = 1 << LINE_BITS;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t state, state_n;

  logic [3:0]           cnt, cnt_n;
  logic                 sel_d, sel_d_n;
  logic                 wr, wr_n;
  logic [LINE_BITS-1:0] idx, idx_n;
  logic [255:0]         wdata, wdata_n;
  logic                 mask_i, mask_d;
  logic                 req_i, req_d;
  logic                 grant, pick_d;
  logic                 enter;

  logic [255:0] mem [DEPTH];

  logic [LINE_BITS-1:0] i_idx, d_idx;
  assign i_idx = i_addr[LINE_BITS+4:5];
  assign d_idx = d_addr[LINE_BITS+4:5];

  // Offset and alias bits do not select a line.
  logic unused_bits;
  assign unused_bits = ^{i_addr[4:0], i_addr[31:LINE_BITS+5],
                         d_addr[4:0], d_addr[31:LINE_BITS+5]};

  // A port is masked for one cycle after completing so a
  // request level still held then is not served again.
  assign req_i = iBlkRead & ~mask_i;
  assign req_d = (dBlkRead | dBlkWrite) & ~mask_d;
  assign grant = req_i | req_d;

`ifdef BLKMEM_DPRIO_EN
  assign pick_d = req_d;
`else
  logic last_d;
  assign pick_d = req_d & (~req_i | ~last_d);
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_d_n = sel_d;
    wr_n    = wr;
    idx_n   = idx;
    wdata_n = wdata;
    unique case (state)
      IDLE: begin
        if (grant) begin
          sel_d_n = pick_d;
          wr_n    = pick_d & dBlkWrite;
          idx_n   = pick_d ? d_idx : i_idx;
          wdata_n = d_block_write;
          cnt_n   = 4'(LATENCY - 1);
          state_n = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_n = cnt - 4'd1;
        if (cnt_n == 4'd0) state_n = RESP;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The array is accessed on the edge that enters RESP, so data,
  // valid and the committed write all appear in the RESP cycle.
  assign enter = (state_n == RESP);
  assign busy  = (state == BUSY);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state               <= IDLE;
      cnt                 <= '0;
      sel_d               <= 1'b0;
      wr                  <= 1'b0;
      idx                 <= '0;
      wdata               <= '0;
      mask_i              <= 1'b0;
      mask_d              <= 1'b0;
      i_block_read        <= '0;
      d_block_read        <= '0;
      i_block_read_valid  <= 1'b0;
      d_block_read_valid  <= 1'b0;
      d_block_write_valid <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      sel_d  <= sel_d_n;
      wr     <= wr_n;
      idx    <= idx_n;
      wdata  <= wdata_n;
      mask_i <= (state == RESP) & ~sel_d;
      mask_d <= (state == RESP) & sel_d;
      i_block_read_valid  <= enter & ~sel_d_n;
      d_block_read_valid  <= enter & sel_d_n & ~wr_n;
      d_block_write_valid <= enter & wr_n;
      if (enter & ~sel_d_n)
        i_block_read <= mem[idx_n];
      if (enter & sel_d_n & ~wr_n)
        d_block_read <= mem[idx_n];
    end
  end

`ifndef BLKMEM_DPRIO_EN
  // Last granted port; D after reset so the first tie goes to I.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      last_d <= 1'b1;
    else if (state == IDLE && grant)
      last_d <= pick_d;
  end
`endif

  // Line array is not reset.
  always_ff @(posedge CLK) begin
    if (enter & wr_n)
      mem[idx_n] <= wdata_n;
  end

endmodule

// File: tb/tb_blk_mem_responder.sv
// tb_blk_mem_responder: directed bench for blk_mem_responder
// (LATENCY=4, LINE_BITS=10), timing and data checks.
module tb_blk_mem_responder;

  localparam int L = 4;
`ifdef BLKMEM_DPRIO_EN
  localparam bit DP = 1'b1;
`else
  localparam bit DP = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [31:0]  i_addr = '0;
  logic         iBlkRead = 1'b0;
  logic [255:0] i_block_read;
  logic         i_block_read_valid;
  logic [31:0]  d_addr = '0;
  logic         dBlkRead = 1'b0;
  logic         dBlkWrite = 1'b0;
  logic [255:0] d_block_write = '0;
  logic [255:0] d_block_read;
  logic         d_block_read_valid;
  logic         d_block_write_valid;
  logic         busy;
  logic [3:0]   outs;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] PA = {8{32'hA5A5_0001}};
  localparam logic [255:0] PB = {8{32'h0B0B_0002}};
  localparam logic [255:0] PC = {8{32'hC3C3_0003}};
  localparam logic [255:0] PE = {8{32'hE1E1_0005}};
  localparam logic [255:0] PF = {8{32'hF0F0_0006}};

  always #5 CLK = ~CLK;

  blk_mem_responder #(.LATENCY(L), .LINE_BITS(10)) dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .i_addr              (i_addr),
    .iBlkRead            (iBlkRead),
    .i_block_read        (i_block_read),
    .i_block_read_valid  (i_block_read_valid),
    .d_addr              (d_addr),
    .dBlkRead            (dBlkRead),
    .dBlkWrite           (dBlkWrite),
    .d_block_write       (d_block_write),
    .d_block_read        (d_block_read),
    .d_block_read_valid  (d_block_read_valid),
    .d_block_write_valid (d_block_write_valid),
    .busy                (busy)
  );

  // {i valid, d read valid, d write valid, busy}
  assign outs = {i_block_read_valid, d_block_read_valid,
                 d_block_write_valid, busy};

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drop;
    iBlkRead  = 1'b0;
    dBlkRead  = 1'b0;
    dBlkWrite = 1'b0;
  endtask

  // One transaction from an idle start; v = {iv, drv, dwv}.
  // hold keeps the request through the cycle after the pulse.
  task automatic op(input logic ir, input logic dr,
                    input logic dw, input logic [31:0] a,
                    input logic [255:0] wd, input logic [2:0] v,
                    input bit hold, input string tag);
    iBlkRead      = ir;
    dBlkRead      = dr;
    dBlkWrite     = dw;
    i_addr        = a;
    d_addr        = a;
    d_block_write = wd;
    for (int k = 1; k < L; k++) begin
      tick;
      chk({tag, "/busy"}, 256'(outs), 256'(4'b0001));
    end
    tick;
    chk({tag, "/valid"}, 256'(outs), 256'({v, 1'b0}));
    tick;
    chk({tag, "/after"}, 256'(outs), 256'(4'b0000));
    if (!hold) drop;
    tick;
    drop;
    chk({tag, "/idle"}, 256'(outs), 256'(4'b0000));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    tick;
    tick;
    chk("rst_outs", 256'(outs), 256'(4'b0000));
    chk("rst_iread", i_block_read, '0);
    chk("rst_dread", d_block_read, '0);
    RESET = 1'b0;
    tick;
    chk("rst_idle", 256'(outs), 256'(4'b0000));

    // simultaneous I and D right after reset
    i_addr   = 32'h2000;
    d_addr   = 32'h3000;
    iBlkRead = 1'b1;
    dBlkRead = 1'b1;
    for (int k = 1; k < L; k++) begin
      tick;
      chk("t2_busy1", 256'(outs), 256'(4'b0001));
    end
    tick;
    chk("t2_first", 256'(outs),
        256'(DP ? 4'b0100 : 4'b1000));
    tick;
    chk("t2_gap", 256'(outs), 256'(4'b0000));
    iBlkRead = DP;
    dBlkRead = !DP;
    for (int k = 1; k < L; k++) begin
      tick;
      chk("t2_busy2", 256'(outs), 256'(4'b0001));
    end
    tick;
    chk("t2_second", 256'(outs),
        256'(DP ? 4'b1000 : 4'b0100));
    tick;
    drop;
    chk("t2_after", 256'(outs), 256'(4'b0000));
    tick;
    chk("t2_idle", 256'(outs), 256'(4'b0000));

    // write then read back
    op(0, 0, 1, 32'h1000, PA, 3'b001, 0, "t1_wr");
    op(0, 1, 0, 32'h1000, '0, 3'b010, 0, "t1_rd");
    chk("t1_data", d_block_read, PA);

    // I holds its request one cycle past the pulse
    op(1, 0, 0, 32'h1000, '0, 3'b100, 1, "t3_hold");
    chk("t3_data", i_block_read, PA);

    // tie after an I grant: D wins either way
    i_addr   = 32'h2000;
    d_addr   = 32'h1000;
    iBlkRead = 1'b1;
    dBlkRead = 1'b1;
    for (int k = 1; k < L; k++) begin
      tick;
      chk("rr_busy1", 256'(outs), 256'(4'b0001));
    end
    tick;
    chk("rr_first", 256'(outs), 256'(4'b0100));
    chk("rr_ddata", d_block_read, PA);
    chk("rr_iuntouched", i_block_read, PA);
    tick;
    chk("rr_gap", 256'(outs), 256'(4'b0000));
    dBlkRead = 1'b0;
    for (int k = 1; k < L; k++) begin
      tick;
      chk("rr_busy2", 256'(outs), 256'(4'b0001));
    end
    tick;
    chk("rr_second", 256'(outs), 256'(4'b1000));
    chk("rr_duntouched", d_block_read, PA);
    tick;
    drop;
    chk("rr_after", 256'(outs), 256'(4'b0000));
    tick;
    chk("rr_idle", 256'(outs), 256'(4'b0000));

    // aliasing and offset bits
    op(0, 0, 1, 32'h0000_0000, PB, 3'b001, 0, "t4_wr");
    op(0, 1, 0, 32'h0000_8000, '0, 3'b010, 0, "t4_alias");
    chk("t4_alias_data", d_block_read, PB);
    op(1, 0, 0, 32'h0000_001C, '0, 3'b100, 0, "t4_off");
    chk("t4_off_data", i_block_read, PB);

    // read and write together act as a write
    op(0, 1, 1, 32'h40, PC, 3'b001, 0, "t6_rw");
    chk("t6_dread_kept", d_block_read, PB);
    op(1, 0, 0, 32'h40, '0, 3'b100, 0, "t6_rd");
    chk("t6_data", i_block_read, PC);

    // reset in the middle of a write
    op(0, 0, 1, 32'h60, PE, 3'b001, 0, "t5_pre");
    dBlkWrite     = 1'b1;
    d_addr        = 32'h60;
    d_block_write = PF;
    tick;
    chk("t5_busy1", 256'(outs), 256'(4'b0001));
    tick;
    chk("t5_busy2", 256'(outs), 256'(4'b0001));
    RESET = 1'b1;
    #1;
    chk("t5_rst_outs", 256'(outs), 256'(4'b0000));
    chk("t5_rst_dread", d_block_read, '0);
    chk("t5_rst_iread", i_block_read, '0);
    tick;
    RESET = 1'b0;
    drop;
    chk("t5_rst_hold", 256'(outs), 256'(4'b0000));
    tick;
    chk("t5_idle", 256'(outs), 256'(4'b0000));
    op(0, 1, 0, 32'h60, '0, 3'b010, 0, "t5_rd");
    chk("t5_data", d_block_read, PE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
